// File: rtl/ads_sample_capture_pkg.sv
// rtl/ads_sample_capture_pkg.sv - shared constants, FSM states and timer helpers for ADS sample capture
package ads_sample_capture_pkg;

    // Line geometry, shared with the AFE control stage.
    localparam int CH_NUM = 64;
    localparam int DW     = 16;
    localparam int CH_W   = $clog2(CH_NUM);
    localparam int CNT_W  = $clog2(CH_NUM + 1);

    // Default ADS timing in CLK_100M cycles.
    localparam int T_SETTLE     = 10;
    localparam int T_CONVST     = 3;
    localparam int BUSY_TMO     = 60;
    localparam int SCLK_DIV     = 2;
    localparam int BUSY_MIN_GAP = 2;

    localparam int TMR_W = 7;

    typedef logic [TMR_W-1:0] tmr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CONV,
        ST_WAIT_BUSY,
        ST_SHIFT,
        ST_DONE
    } state_e;

    // Terminal timer value for a phase that lasts 'cycles' clocks.
    function automatic tmr_t tmr_last(input int cycles);
        return tmr_t'(cycles - 1);
    endfunction

endpackage

// File: rtl/ads_sample_capture_if.sv
// rtl/ads_sample_capture_if.sv - tagged sample output handshake towards line assembly
interface ads_sample_capture_if;
    import ads_sample_capture_pkg::*;

    logic            SMP_VALID;
    logic            SMP_READY;
    logic [DW-1:0]   SMP_DATA;
    logic [CH_W-1:0] SMP_CH;
    logic            SMP_LAST;

    modport master (
        output SMP_VALID,
        output SMP_DATA,
        output SMP_CH,
        output SMP_LAST,
        input  SMP_READY
    );

    modport slave (
        input  SMP_VALID,
        input  SMP_DATA,
        input  SMP_CH,
        input  SMP_LAST,
        output SMP_READY
    );

endinterface

// File: rtl/ads_serial_rx.sv
// rtl/ads_serial_rx.sv - CS_N/SCLK generator and MSB-first DW-bit shifter for the ADS readout
module ads_serial_rx
    import ads_sample_capture_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          sdo,
    output logic          cs_n,
    output logic          sclk,
    output logic          done,
    output logic [DW-1:0] data
);
    localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int BIT_W = $clog2(DW + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BITS_ALL = BIT_W'(DW);

    logic             active_q, active_d;
    logic             cs_n_q, cs_n_d;
    logic             sclk_q, sclk_d;
    logic             done_q, done_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [DW-1:0]    shreg_q, shreg_d;

    // SCLK toggles every SCLK_DIV cycles; data captured on rise, frame closes after the last fall.
    always_comb begin
        active_d = active_q;
        cs_n_d   = cs_n_q;
        sclk_d   = sclk_q;
        done_d   = 1'b0;
        div_d    = div_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        if (start && !active_q) begin
            active_d = 1'b1;
            cs_n_d   = 1'b0;
            sclk_d   = 1'b0;
            div_d    = '0;
            bit_d    = '0;
        end else if (active_q) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                if (!sclk_q) begin
                    sclk_d  = 1'b1;
                    shreg_d = {shreg_q[DW-2:0], sdo};
                    bit_d   = bit_q + 1'b1;
                end else begin
                    sclk_d = 1'b0;
                    if (bit_q == BITS_ALL) begin
                        active_d = 1'b0;
                        cs_n_d   = 1'b1;
                        done_d   = 1'b1;
                    end
                end
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    // Serial state; chip select and clock park inactive on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            cs_n_q   <= 1'b1;
            sclk_q   <= 1'b0;
            done_q   <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
        end else begin
            active_q <= active_d;
            cs_n_q   <= cs_n_d;
            sclk_q   <= sclk_d;
            done_q   <= done_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
        end
    end

    assign cs_n = cs_n_q;
    assign sclk = sclk_q;
    assign done = done_q;
    assign data = shreg_q;

endmodule

// File: rtl/ads_sample_capture.sv
// rtl/ads_sample_capture.sv - ADS settle/convert/readout sequencer emitting tagged samples; option macro ADS_CAPTURE_TEST_PATTERN_EN
module ads_sample_capture
    import ads_sample_capture_pkg::*;
(
    input  logic CLK_100M,
    input  logic CLK_RST_N,
    input  logic ADS_INIT_OK,
    input  logic AFE_CLK,
    input  logic AFE_IRST,
    output logic ADS_CONVST,
    input  logic ADS_BUSY,
    output logic ADS_CS_N,
    output logic ADS_SCLK,
    input  logic ADS_SDO,
    ads_sample_capture_if.master smp,
    output logic ERR_OVF,
    output logic ERR_TMO
);
    localparam tmr_t SETTLE_LAST = tmr_last(T_SETTLE);
    localparam tmr_t CONVST_LAST = tmr_last(T_CONVST);
    localparam tmr_t TMO_LAST    = tmr_last(BUSY_TMO);
    localparam tmr_t BUSY_GAP    = tmr_t'(BUSY_MIN_GAP);
    localparam cnt_t CNT_FULL    = cnt_t'(CH_NUM);
    localparam cnt_t CNT_LAST    = cnt_t'(CH_NUM - 1);

    state_e          state_q, state_d;
    tmr_t            tmr_q, tmr_d;
    cnt_t            cnt_q, cnt_d;
    logic            afe_clk_q, afe_clk_d;
    logic            irst_q, irst_d;
    logic            busy_s1_q, busy_s1_d;
    logic            busy_s2_q, busy_s2_d;
    logic            convst_q, convst_d;
    logic            valid_q, valid_d;
    logic [DW-1:0]   data_q, data_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic            last_q, last_d;
    logic            err_ovf_q, err_ovf_d;
    logic            err_tmo_q, err_tmo_d;

    logic            afe_rise, irst_rise;
    logic            rx_start, rx_done, load, cnt_inc;
    logic [DW-1:0]   rx_data, sample;

`ifdef ADS_CAPTURE_TEST_PATTERN_EN
    logic [DW-CH_W-1:0] line_cnt_q, line_cnt_d;

    // Line counter advances on every integrator reset so each line carries a distinct pattern.
    always_comb begin
        line_cnt_d = irst_rise ? line_cnt_q + 1'b1 : line_cnt_q;
    end

    always_ff @(posedge CLK_100M or negedge CLK_RST_N) begin
        if (!CLK_RST_N) line_cnt_q <= '0;
        else            line_cnt_q <= line_cnt_d;
    end

    assign sample = {line_cnt_q, cnt_q[CH_W-1:0]};
`else
    assign sample = rx_data;
`endif

    assign afe_rise  = AFE_CLK & ~afe_clk_q;
    assign irst_rise = AFE_IRST & ~irst_q;

    ads_serial_rx u_rx (
        .clk   (CLK_100M),
        .rst_n (CLK_RST_N),
        .start (rx_start),
        .sdo   (ADS_SDO),
        .cs_n  (ADS_CS_N),
        .sclk  (ADS_SCLK),
        .done  (rx_done),
        .data  (rx_data)
    );

    // Input edge history and two-stage BUSY synchroniser.
    always_comb begin
        afe_clk_d = AFE_CLK;
        irst_d    = AFE_IRST;
        busy_s1_d = ADS_BUSY;
        busy_s2_d = busy_s1_q;
    end

    // Capture sequencer: next state, phase timer, channel counter and error flags.
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        rx_start  = 1'b0;
        load      = 1'b0;
        cnt_inc   = 1'b0;
        err_ovf_d = err_ovf_q;
        err_tmo_d = err_tmo_q;
        case (state_q)
            ST_IDLE: begin
                if (afe_rise && ADS_INIT_OK && (cnt_q < CNT_FULL)) begin
                    state_d = ST_SETTLE;
                    tmr_d   = '0;
                end
            end
            ST_SETTLE: begin
                if (tmr_q == SETTLE_LAST) begin
                    state_d = ST_CONV;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_CONV: begin
                if (tmr_q == CONVST_LAST) begin
                    state_d = ST_WAIT_BUSY;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_WAIT_BUSY: begin
                // Ignore BUSY for a short gap: the synchronised copy may still show the pre-conversion level.
                if (!busy_s2_q && (tmr_q >= BUSY_GAP)) begin
                    state_d  = ST_SHIFT;
                    rx_start = 1'b1;
                end else if (tmr_q == TMO_LAST) begin
                    state_d   = ST_IDLE;
                    err_tmo_d = 1'b1;
                    cnt_inc   = 1'b1;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (rx_done) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_inc = 1'b1;
                if (!valid_q || smp.SMP_READY) load = 1'b1;
                else                          err_ovf_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // A new line restarts channel numbering without disturbing a conversion in flight.
        cnt_d = cnt_q;
        if (irst_rise)                        cnt_d = '0;
        else if (cnt_inc && cnt_q != CNT_FULL) cnt_d = cnt_q + 1'b1;

        convst_d = (state_d == ST_CONV);
    end

    // Output register: hold until accepted; a load in the accept cycle replaces the data.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ch_d    = ch_q;
        last_d  = last_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = sample;
            ch_d    = cnt_q[CH_W-1:0];
            last_d  = (cnt_q == CNT_LAST);
        end else if (valid_q && smp.SMP_READY) begin
            valid_d = 1'b0;
        end
    end

    // All sequencer and output state; reset forces every pin to its idle level.
    always_ff @(posedge CLK_100M or negedge CLK_RST_N) begin
        if (!CLK_RST_N) begin
            state_q   <= ST_IDLE;
            tmr_q     <= '0;
            cnt_q     <= '0;
            afe_clk_q <= 1'b0;
            irst_q    <= 1'b0;
            busy_s1_q <= 1'b0;
            busy_s2_q <= 1'b0;
            convst_q  <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            ch_q      <= '0;
            last_q    <= 1'b0;
            err_ovf_q <= 1'b0;
            err_tmo_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            cnt_q     <= cnt_d;
            afe_clk_q <= afe_clk_d;
            irst_q    <= irst_d;
            busy_s1_q <= busy_s1_d;
            busy_s2_q <= busy_s2_d;
            convst_q  <= convst_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            ch_q      <= ch_d;
            last_q    <= last_d;
            err_ovf_q <= err_ovf_d;
            err_tmo_q <= err_tmo_d;
        end
    end

    assign ADS_CONVST    = convst_q;
    assign smp.SMP_VALID = valid_q;
    assign smp.SMP_DATA  = data_q;
    assign smp.SMP_CH    = ch_q;
    assign smp.SMP_LAST  = last_q;
    assign ERR_OVF       = err_ovf_q;
    assign ERR_TMO       = err_tmo_q;

endmodule

// File: tb/tb_ads_sample_capture.sv
// tb/tb_ads_sample_capture.sv - self-checking bench for ads_sample_capture with ADS device model and sample scoreboard
module tb_ads_sample_capture;

    logic clk = 1'b0;
    logic rst_n;
    logic ADS_INIT_OK, AFE_CLK, AFE_IRST;
    logic ADS_CONVST, ADS_BUSY, ADS_CS_N, ADS_SCLK, ADS_SDO;
    logic ERR_OVF, ERR_TMO;

    always #5 clk = ~clk;

    ads_sample_capture_if smp_if();

    ads_sample_capture dut (
        .CLK_100M    (clk),
        .CLK_RST_N   (rst_n),
        .ADS_INIT_OK (ADS_INIT_OK),
        .AFE_CLK     (AFE_CLK),
        .AFE_IRST    (AFE_IRST),
        .ADS_CONVST  (ADS_CONVST),
        .ADS_BUSY    (ADS_BUSY),
        .ADS_CS_N    (ADS_CS_N),
        .ADS_SCLK    (ADS_SCLK),
        .ADS_SDO     (ADS_SDO),
        .smp         (smp_if),
        .ERR_OVF     (ERR_OVF),
        .ERR_TMO     (ERR_TMO)
    );

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    logic [22:0] got_q[$];
    logic [22:0] exp_q[$];

    int   m_ch = 0;
    int   m_line = 0;
    int   m_last_start = -1000;
    logic m_ovf = 1'b0;
    logic m_tmo = 1'b0;
    logic m_occ = 1'b0;

    logic        busy_stuck = 1'b0;
    logic [15:0] sdo_word = 16'h0;
    int          bit_idx = 16;
    int          busy_cnt = 0;
    logic        cv_prev = 1'b0;
    int          convst_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        cv_prev <= ADS_CONVST;
        if (ADS_CONVST && !cv_prev) begin
            busy_cnt <= $urandom_range(42, 30);
            ADS_BUSY <= 1'b1;
        end else begin
            if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
            ADS_BUSY <= busy_stuck || (busy_cnt > 1);
        end
    end

    always @(posedge ADS_CONVST) convst_cnt <= convst_cnt + 1;
    always @(negedge ADS_CS_N) bit_idx <= 0;
    always @(posedge ADS_SCLK) bit_idx <= bit_idx + 1;
    assign ADS_SDO = (bit_idx < 16) ? sdo_word[15 - bit_idx] : 1'b0;

    always @(negedge clk) begin
        if (rst_n && smp_if.SMP_VALID && smp_if.SMP_READY)
            got_q.push_back({smp_if.SMP_DATA, smp_if.SMP_CH, smp_if.SMP_LAST});
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference behaviour for one AFE_CLK rise, then drive the rise itself.
    task automatic afe_rise(input logic [15:0] word);
        logic [15:0] d;
        if (ADS_INIT_OK && m_ch < 64 && (cyc - m_last_start) >= 130) begin
            m_last_start = cyc;
            sdo_word = word;
            if (busy_stuck) begin
                m_tmo = 1'b1;
            end else if (m_occ) begin
                m_ovf = 1'b1;
            end else begin
`ifdef ADS_CAPTURE_TEST_PATTERN_EN
                d = {m_line[9:0], 6'(m_ch)};
`else
                d = word;
`endif
                exp_q.push_back({d, 6'(m_ch), (m_ch == 63)});
                if (!smp_if.SMP_READY) m_occ = 1'b1;
            end
            m_ch++;
        end
        AFE_CLK = 1'b1;
        idle(4);
        AFE_CLK = 1'b0;
    endtask

    task automatic afe_edge(input logic [15:0] word, input int gap);
        afe_rise(word);
        idle(gap - 4);
    endtask

    task automatic irst();
        m_ch = 0;
        m_line++;
        AFE_IRST = 1'b1;
        idle(2);
        AFE_IRST = 1'b0;
        idle(2);
    endtask

    task automatic set_ready(input logic r);
        smp_if.SMP_READY = r;
        if (r) m_occ = 1'b0;
    endtask

    task automatic sb_check(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_sample%0d", tag, i), got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic model_reset();
        m_ch = 0;
        m_line = 0;
        m_ovf = 1'b0;
        m_tmo = 1'b0;
        m_occ = 1'b0;
        m_last_start = cyc - 1000;
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        ADS_INIT_OK = 1'b0;
        AFE_CLK = 1'b0;
        AFE_IRST = 1'b0;
        smp_if.SMP_READY = 1'b1;
        idle(3);
        check("rst_convst", ADS_CONVST, 0);
        check("rst_cs_n", ADS_CS_N, 1);
        check("rst_sclk", ADS_SCLK, 0);
        check("rst_valid", smp_if.SMP_VALID, 0);
        check("rst_data", smp_if.SMP_DATA, 0);
        check("rst_ch", smp_if.SMP_CH, 0);
        check("rst_last", smp_if.SMP_LAST, 0);
        check("rst_err_ovf", ERR_OVF, 0);
        check("rst_err_tmo", ERR_TMO, 0);
        rst_n = 1'b1;
        idle(2);
        ADS_INIT_OK = 1'b1;

        // Nominal line plus six surplus edges that must be ignored.
        for (int k = 0; k < 70; k++) afe_edge(16'hA5C3 + 16'(m_ch), 130);
        sb_check("nominal");
        check("nominal_err_ovf", ERR_OVF, m_ovf);
        check("nominal_err_tmo", ERR_TMO, m_tmo);

        // Line restart after channel 20.
        irst();
        for (int k = 0; k < 21; k++) afe_edge(16'($urandom), 130);
        irst();
        afe_edge(16'($urandom), 130);
        sb_check("restart");

        // Edge during an active capture, INIT_OK low, INIT_OK dropping mid-conversion.
        afe_edge(16'($urandom), 20);
        afe_edge(16'($urandom), 130);
        afe_edge(16'($urandom), 130);
        ADS_INIT_OK = 1'b0;
        afe_edge(16'($urandom), 130);
        ADS_INIT_OK = 1'b1;
        afe_rise(16'($urandom));
        idle(30);
        ADS_INIT_OK = 1'b0;
        idle(96);
        ADS_INIT_OK = 1'b1;
        sb_check("ignore_init");

        // Backpressure across two conversions.
        irst();
        set_ready(1'b0);
        afe_edge(16'($urandom), 130);
        check("bp_first_valid", smp_if.SMP_VALID, 1);
        check("bp_first_ch", smp_if.SMP_CH, 0);
        afe_edge(16'($urandom), 130);
        check("bp_hold_valid", smp_if.SMP_VALID, 1);
        check("bp_hold_data", smp_if.SMP_DATA, exp_q[0][22:7]);
        check("bp_hold_ch", smp_if.SMP_CH, 0);
        check("bp_err_ovf", ERR_OVF, m_ovf);
        set_ready(1'b1);
        idle(2);
        afe_edge(16'($urandom), 130);
        sb_check("backpressure");

        // BUSY stuck high, then normal capture on the following edge.
        busy_stuck = 1'b1;
        begin
            int c0;
            c0 = convst_cnt;
            afe_edge(16'($urandom), 130);
            check("tmo_convst_pulses", convst_cnt - c0, 1);
        end
        check("tmo_err_tmo", ERR_TMO, m_tmo);
        busy_stuck = 1'b0;
        afe_edge(16'($urandom), 130);
        sb_check("timeout");

        // Asynchronous reset in the middle of the serial readout.
        afe_rise(16'($urandom));
        for (int k = 0; k < 300 && bit_idx != 8; k++) tick();
        check("mid_shift_bit", bit_idx, 8);
        rst_n = 1'b0;
        #1;
        check("mid_rst_cs_n", ADS_CS_N, 1);
        check("mid_rst_sclk", ADS_SCLK, 0);
        check("mid_rst_valid", smp_if.SMP_VALID, 0);
        check("mid_rst_convst", ADS_CONVST, 0);
        idle(2);
        rst_n = 1'b1;
        model_reset();
        idle(130);
        afe_edge(16'($urandom), 130);
        afe_edge(16'($urandom), 130);
        sb_check("post_reset");
        check("post_rst_err_ovf", ERR_OVF, 0);
        check("post_rst_err_tmo", ERR_TMO, 0);

`ifdef ADS_CAPTURE_TEST_PATTERN_EN
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        model_reset();
        idle(2);
        irst();
        irst();
        irst();
        for (int k = 0; k < 6; k++) afe_edge(16'($urandom), 130);
        if (got_q.size() == 6) check("tp_ch5_data", got_q[5][22:7], 16'h00C5);
        else check("tp_count6", got_q.size(), 6);
        sb_check("test_pattern");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
